// File: rtl/branch_sched.sv
// D-stage branch sequencer: holds decode until the branch operands are forwarded,
// resolves the condition, pulses a redirect and keeps taken/not-taken statistics.
module branch_sched #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [2:0]       br_op,
  input  logic [31:0]      br_pc,
  input  logic [15:0]      br_imm,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             flush,
  output logic             stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             resolved,
  output logic             wd_err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  localparam logic [2:0] OP_BEQ  = 3'd1;
  localparam logic [2:0] OP_BNE  = 3'd2;
  localparam logic [2:0] OP_BGTZ = 3'd3;
  localparam logic [2:0] OP_BGEZ = 3'd4;
  localparam logic [7:0] WAIT_LIMIT = MAX_WAIT[7:0];

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [2:0]       r_op;
  logic [31:0]      r_pc;
  logic [15:0]      r_imm;
  logic [7:0]       r_waitCnt;
  logic             r_redirect;
  logic             r_resolved;
  logic             r_wdErr;
  logic [31:0]      r_redirectPc;
  logic [CNT_W-1:0] r_takenCnt;
  logic [CNT_W-1:0] r_ntakenCnt;

  logic        w_opValid;
  logic        w_accept;
  logic        w_needRt;
  logic        w_ready;
  logic        w_taken;
  logic [7:0]  w_waitNext;
  logic        w_timeout;
  logic [31:0] w_target;
  logic        w_doResolve;
  logic        w_doRedirect;
  logic        w_doAbort;
  logic        w_incTaken;
  logic        w_incNtaken;
  logic        w_waitStep;

  assign w_opValid  = (br_op != 3'd0) && (br_op <= OP_BGEZ);
  assign w_accept   = br_valid && w_opValid && !flush;
  assign w_needRt   = (r_op == OP_BEQ) || (r_op == OP_BNE);
  assign w_ready    = rs_ready && (rt_ready || !w_needRt);
  assign w_waitNext = r_waitCnt + 8'd1;
  assign w_timeout  = (w_waitNext == WAIT_LIMIT);
  assign w_target   = r_pc + 32'd4 + {{14{r_imm[15]}}, r_imm, 2'b00};

  always_comb begin
    w_taken = 1'b0;
    case (r_op)
      OP_BEQ:  w_taken = (rs_val == rt_val);
      OP_BNE:  w_taken = (rs_val != rt_val);
      OP_BGTZ: w_taken = !rs_val[31] && (rs_val != 32'd0);
      OP_BGEZ: w_taken = !rs_val[31];
      default: w_taken = 1'b0;
    endcase
  end

  // Flush has priority over evaluation; evaluation has priority over the watchdog.
  always_comb begin
    w_nextState  = r_state;
    stall        = 1'b0;
    w_doResolve  = 1'b0;
    w_doRedirect = 1'b0;
    w_doAbort    = 1'b0;
    w_incTaken   = 1'b0;
    w_incNtaken  = 1'b0;
    w_waitStep   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          stall       = 1'b1;
          w_nextState = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_nextState = S_IDLE;
        end else begin
          stall = 1'b1;
          if (w_ready) begin
            w_doResolve  = 1'b1;
            w_doRedirect = w_taken;
            w_incTaken   = w_taken;
            w_incNtaken  = !w_taken;
            w_nextState  = S_IDLE;
          end else if (w_timeout) begin
            w_doResolve = 1'b1;
            w_doAbort   = 1'b1;
            w_incNtaken = 1'b1;
            w_nextState = S_IDLE;
          end else begin
            w_waitStep = 1'b1;
          end
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op         <= 3'd0;
      r_pc         <= 32'd0;
      r_imm        <= 16'd0;
      r_waitCnt    <= 8'd0;
      r_redirect   <= 1'b0;
      r_resolved   <= 1'b0;
      r_wdErr      <= 1'b0;
      r_redirectPc <= 32'd0;
      r_takenCnt   <= '0;
      r_ntakenCnt  <= '0;
    end else begin
      r_state    <= w_nextState;
      r_redirect <= w_doRedirect;
      r_resolved <= w_doResolve;
      if (w_doRedirect) r_redirectPc <= w_target;
      if (w_doAbort) r_wdErr <= 1'b1;
      if (r_state == S_IDLE && w_accept) begin
        r_op      <= br_op;
        r_pc      <= br_pc;
        r_imm     <= br_imm;
        r_waitCnt <= 8'd0;
      end else if (w_waitStep) begin
        r_waitCnt <= w_waitNext;
      end
      if (w_incTaken && r_takenCnt != '1) r_takenCnt <= r_takenCnt + CNT_W'(1);
      if (w_incNtaken && r_ntakenCnt != '1) r_ntakenCnt <= r_ntakenCnt + CNT_W'(1);
    end
  end

  assign redirect    = r_redirect;
  assign resolved    = r_resolved;
  assign wd_err      = r_wdErr;
  assign redirect_pc = r_redirectPc;
  assign taken_cnt   = r_takenCnt;
  assign ntaken_cnt  = r_ntakenCnt;

endmodule

// File: doc/branch_sched.md
Name: branch_sched

Overview:
- Sequencing controller for the D-stage branch comparator of the pipelined MIPS core.
- Accepts a decoded branch and stalls decode until the needed register operands are forwarded-ready.
- Evaluates the condition, then issues a one-cycle redirect with the branch target.
- Keeps saturating taken/not-taken statistics and a stall watchdog.

Parameters:
MAX_WAIT, 8, maximum WAIT cycles before the watchdog aborts the branch (1..255)
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
br_valid  input  1  D stage holds a branch this cycle
br_op  input  3  condition: 1 beq, 2 bne, 3 bgtz, 4 bgez; 0 and 5-7 invalid
br_pc  input  32  PC of the branch instruction
br_imm  input  16  branch offset field
rs_val  input  32  forwarded rs value
rt_val  input  32  forwarded rt value
rs_ready  input  1  rs_val is final this cycle
rt_ready  input  1  rt_val is final this cycle
flush  input  1  squash any pending branch
stall  output  1  freeze PC/IF/D (combinational from state and inputs)
redirect  output  1  one-cycle pulse: branch taken
redirect_pc  output  32  target, valid when redirect=1
resolved  output  1  one-cycle pulse: branch decided (taken or not)
wd_err  output  1  sticky watchdog error
taken_cnt  output  CNT_W  saturating count of taken branches
ntaken_cnt  output  CNT_W  saturating count of not-taken and aborted branches

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State goes to IDLE.
  - redirect, resolved, wd_err = 0; redirect_pc = 0; counters = 0; wait counter = 0.
  - Reset overrides everything, including flush.
- States: IDLE, WAIT.
- IDLE:
  - Accept when br_valid=1, br_op in 1..4 and flush=0.
  - On accept: latch op, br_pc, br_imm; clear the wait counter; next state WAIT.
  - Invalid op or br_valid=0: no action, stall=0.
- Operand need:
  - beq/bne need rs_ready and rt_ready.
  - bgtz/bgez need rs_ready only; rt_ready is ignored.
- WAIT, each cycle:
  - flush=1: go to IDLE; no redirect, no resolved, no counter update.
  - Otherwise, if the needed operands are ready, evaluate using the current rs_val/rt_val:
    - beq: rs==rt. bne: rs!=rt.
    - bgtz: signed rs>0. bgez: signed rs>=0.
  - On evaluation:
    - Next edge: resolved=1.
    - If taken: redirect=1, redirect_pc = latched_pc + 4 + (sign-extended imm << 2), mod 2^32 (wrap-around allowed).
    - If not taken: redirect=0.
    - The matching counter increments, saturating at all-ones. State goes to IDLE.
  - Otherwise, increment the wait counter. When it reaches MAX_WAIT:
    - Next edge: wd_err=1 (sticky until reset).
    - resolved=1, redirect=0, ntaken_cnt increments; state goes to IDLE.
- redirect and resolved are registered one-cycle pulses, cleared on the following edge.
  - redirect_pc holds its last value when redirect=0.
- stall = (IDLE and accept) or (WAIT and not flush).
  - Accept at cycle T, operands ready at T+1: stall high in T and T+1; redirect/resolved high in T+2 with stall low.
- Back-to-back: a new branch may be accepted in the same cycle redirect/resolved is high (state is IDLE).
- flush in the IDLE accept cycle blocks the accept.

Test Plan:
- Reset, then beq with br_pc=0x00003000, br_imm=0x0004, rs=rt=5, both ready at T+1 -> stall in T and T+1; T+2: redirect=1, redirect_pc=0x00003014, resolved=1, taken_cnt=1.
- bne with rs=rt=7, ready at T+1 -> T+2: resolved=1, redirect=0, ntaken_cnt=1, stall=0.
- bgez with rs=0xFFFFFFFF, rt_ready held 0, rs_ready=1 -> not taken (signed -1); bgtz with rs=1, br_imm=0xFFFF, br_pc=0x00003000 -> redirect_pc=0x00003000.
- beq with rt_ready never asserted, MAX_WAIT=8 -> stall for 9 cycles; then wd_err=1 (sticky), resolved=1, redirect=0, ntaken_cnt+1.
- Accept beq, hold operands not ready 2 cycles, then pulse flush -> state IDLE next edge, no redirect/resolved, counters unchanged; br_op=5 with br_valid=1 -> stall=0, no response.
- Reset asserted mid-WAIT with operands ready the same cycle -> no redirect; all outputs and counters 0. CNT_W=2 with 5 taken branches -> taken_cnt saturates at 3.
